// File: rtl/apb_fmc_initiator.sv
// APB completer that replays each 32-bit transfer as a synchronous multiplexed
// FMC bus cycle (16-bit AD, 3 high address bits, NWAIT flow control).
module apb_fmc_initiator #(
  parameter int unsigned ADDR_CYCLES    = 2,
  parameter int unsigned DATA_LATENCY   = 1,
  parameter int unsigned IDLE_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        apb_psel,
  input  logic        apb_penable,
  input  logic        apb_pwrite,
  input  logic [19:0] apb_paddr,
  input  logic [31:0] apb_pwdata,
  input  logic [3:0]  apb_pstrb,
  output logic        apb_pready,
  output logic [31:0] apb_prdata,
  output logic        apb_pslverr,
  output logic        fmc_cs_n,
  output logic        fmc_nl_nadv,
  output logic        fmc_nwe,
  output logic        fmc_noe,
  output logic [1:0]  fmc_nbl,
  output logic [2:0]  fmc_a_hi,
  output logic [15:0] fmc_ad_out,
  output logic        fmc_ad_oe,
  input  logic [15:0] fmc_ad_in,
  input  logic        fmc_nwait
);

  localparam int unsigned PH_MAX = (ADDR_CYCLES > DATA_LATENCY)
                                   ? ((ADDR_CYCLES > IDLE_CYCLES) ? ADDR_CYCLES : IDLE_CYCLES)
                                   : ((DATA_LATENCY > IDLE_CYCLES) ? DATA_LATENCY : IDLE_CYCLES);
  localparam int unsigned CNT_W  = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, LATENCY, DATA_LO, DATA_HI, RECOVER, RESP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                err_q, err_d;
  logic                write_q, write_d;
  logic [18:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          strb_q, strb_d;

  logic                cs_n_d, nadv_d, nwe_d, noe_d, ad_oe_d, pready_d, pslverr_d;
  logic [1:0]          nbl_d;
  logic [2:0]          a_hi_d;
  logic [15:0]         ad_out_d;
  logic [31:0]         prdata_d;
  state_t              done_state;
  logic [CNT_W-1:0]    done_cnt;

  // Byte address bit 0 has no meaning on a 16-bit bus.
  logic unused_paddr0;
  assign unused_paddr0 = apb_paddr[0];

  // Sequencing: phase counters count down to zero; waits count up to the limit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    err_d    = err_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    prdata_d = apb_prdata;
    done_state = (IDLE_CYCLES == 0) ? RESP : RECOVER;
    done_cnt   = CNT_W'(IDLE_CYCLES - 1);

    case (state_q)
      IDLE: begin
        if (apb_psel && !apb_penable) begin
          write_d  = apb_pwrite;
          addr_d   = apb_paddr[19:1];
          wdata_d  = apb_pwdata;
          strb_d   = apb_pstrb;
          prdata_d = '0;
          err_d    = 1'b0;
          wait_d   = '0;
          cnt_d    = CNT_W'(ADDR_CYCLES - 1);
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (DATA_LATENCY == 0) begin
          state_d = DATA_LO;
        end else begin
          cnt_d   = CNT_W'(DATA_LATENCY - 1);
          state_d = LATENCY;
        end
      end
      LATENCY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else             state_d = DATA_LO;
      end
      DATA_LO, DATA_HI: begin
        if (fmc_nwait) begin
          wait_d = '0;
          if (!write_q) begin
            if (state_q == DATA_LO) prdata_d[15:0]  = fmc_ad_in;
            else                    prdata_d[31:16] = fmc_ad_in;
          end
          if (state_q == DATA_LO) begin
            state_d = DATA_HI;
          end else begin
            state_d = done_state;
            cnt_d   = done_cnt;
          end
        end else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = done_state;
          cnt_d   = done_cnt;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      RECOVER: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else             state_d = RESP;
      end
      RESP: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin values for the coming cycle, decoded from the next state.
  always_comb begin
    cs_n_d    = 1'b1;
    nadv_d    = 1'b1;
    nwe_d     = 1'b1;
    noe_d     = 1'b1;
    nbl_d     = 2'b11;
    a_hi_d    = fmc_a_hi;
    ad_out_d  = fmc_ad_out;
    ad_oe_d   = 1'b0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;

    case (state_d)
      ADDR: begin
        cs_n_d   = 1'b0;
        nadv_d   = 1'b0;
        nwe_d    = !write_d;
        a_hi_d   = addr_d[18:16];
        ad_out_d = addr_d[15:0];
        ad_oe_d  = 1'b1;
      end
      LATENCY, DATA_LO, DATA_HI: begin
        cs_n_d = 1'b0;
        nwe_d  = !write_d;
        if (write_d) begin
          ad_oe_d  = 1'b1;
          ad_out_d = (state_d == DATA_HI) ? wdata_d[31:16] : wdata_d[15:0];
          if (state_d == DATA_LO) nbl_d = ~strb_d[1:0];
          if (state_d == DATA_HI) nbl_d = ~strb_d[3:2];
        end else begin
          noe_d = 1'b0;
          if (state_d != LATENCY) nbl_d = 2'b00;
        end
      end
      RESP: begin
        pready_d  = 1'b1;
        pslverr_d = err_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wait_q      <= '0;
      err_q       <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      fmc_cs_n    <= 1'b1;
      fmc_nl_nadv <= 1'b1;
      fmc_nwe     <= 1'b1;
      fmc_noe     <= 1'b1;
      fmc_nbl     <= 2'b11;
      fmc_a_hi    <= '0;
      fmc_ad_out  <= '0;
      fmc_ad_oe   <= 1'b0;
      apb_pready  <= 1'b0;
      apb_pslverr <= 1'b0;
      apb_prdata  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      fmc_cs_n    <= cs_n_d;
      fmc_nl_nadv <= nadv_d;
      fmc_nwe     <= nwe_d;
      fmc_noe     <= noe_d;
      fmc_nbl     <= nbl_d;
      fmc_a_hi    <= a_hi_d;
      fmc_ad_out  <= ad_out_d;
      fmc_ad_oe   <= ad_oe_d;
      apb_pready  <= pready_d;
      apb_pslverr <= pslverr_d;
      apb_prdata  <= prdata_d;
    end
  end

endmodule
